// File: rtl/fft_stage_sequencer.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT over a dual-port RAM: one RD cycle then one WR cycle per butterfly.
// Optional macro FFT_SEQ_INVERSE_EN adds i_inverse / o_tw_conj for inverse transforms.
module fft_stage_sequencer #(
  parameter int LOG2N  = 3,
  parameter int RD_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
`ifdef FFT_SEQ_INVERSE_EN
  input  logic             i_inverse,
  output logic             o_tw_conj,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [LOG2N-1:0] o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr_a,
  output logic [LOG2N-1:0] o_rd_addr_b,
  output logic [LOG2N-2:0] o_tw_addr,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_a,
  output logic [LOG2N-1:0] o_wr_addr_b
);

  generate
    if (RD_LAT != 1) begin : g_rd_lat_check
      $error("fft_stage_sequencer: RD_LAT must be 1 in this revision");
    end
    if (LOG2N < 2 || LOG2N > 12) begin : g_log2n_check
      $error("fft_stage_sequencer: LOG2N must be in 2..12");
    end
  endgenerate

  localparam logic [LOG2N-2:0] BFLY_LAST  = '1;
  localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] stage_q, stage_d;
  logic [LOG2N-2:0] bfly_q, bfly_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic [LOG2N-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [LOG2N-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [LOG2N-2:0] tw_addr_q, tw_addr_d;
  logic [LOG2N-1:0] wr_addr_a_q, wr_addr_a_d;
  logic [LOG2N-1:0] wr_addr_b_q, wr_addr_b_d;
`ifdef FFT_SEQ_INVERSE_EN
  logic             inv_q, inv_d;
  logic             tw_conj_q, tw_conj_d;
`endif

  // Butterfly b of stage s: the lower s bits of b pick the position inside a group,
  // the remaining bits pick the group, which is 2^(s+1) samples wide.
  function automatic logic [LOG2N-1:0] bfly_addr_a(input logic [LOG2N-1:0] s,
                                                   input logic [LOG2N-2:0] b);
    logic [LOG2N-1:0] bx;
    logic [LOG2N-1:0] mask;
    bx   = {1'b0, b};
    mask = (LOG2N'(1) << s) - LOG2N'(1);
    return ((bx >> s) << (s + LOG2N'(1))) | (bx & mask);
  endfunction

  function automatic logic [LOG2N-2:0] bfly_tw(input logic [LOG2N-1:0] s,
                                               input logic [LOG2N-2:0] b);
    logic [LOG2N-1:0] bx;
    logic [LOG2N-1:0] mask;
    bx   = {1'b0, b};
    mask = (LOG2N'(1) << s) - LOG2N'(1);
    return (LOG2N-1)'((bx & mask) << (LOG2N'(LOG2N - 1) - s));
  endfunction

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
`ifdef FFT_SEQ_INVERSE_EN
    inv_d   = inv_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RD;
          stage_d = '0;
          bfly_d  = '0;
`ifdef FFT_SEQ_INVERSE_EN
          inv_d   = i_inverse;
`endif
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        if (stage_q == STAGE_LAST && bfly_q == BFLY_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD;
          if (bfly_q == BFLY_LAST) begin
            bfly_d  = '0;
            stage_d = stage_q + LOG2N'(1);
          end else begin
            bfly_d  = bfly_q + (LOG2N-1)'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state needs, so nothing
    // combinational reaches a port.
    rd_en_d = (state_d == S_RD);
    wr_en_d = (state_d == S_WR);
    busy_d  = rd_en_d | wr_en_d;
    done_d  = (state_d == S_DONE);

    rd_addr_a_d = rd_addr_a_q;
    rd_addr_b_d = rd_addr_b_q;
    tw_addr_d   = tw_addr_q;
    if (state_d == S_RD) begin
      rd_addr_a_d = bfly_addr_a(stage_d, bfly_d);
      rd_addr_b_d = bfly_addr_a(stage_d, bfly_d) + (LOG2N'(1) << stage_d);
      tw_addr_d   = bfly_tw(stage_d, bfly_d);
    end

    wr_addr_a_d = wr_addr_a_q;
    wr_addr_b_d = wr_addr_b_q;
    if (state_d == S_WR) begin
      wr_addr_a_d = rd_addr_a_q;
      wr_addr_b_d = rd_addr_b_q;
    end

`ifdef FFT_SEQ_INVERSE_EN
    tw_conj_d = wr_en_d & inv_q;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      bfly_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
`ifdef FFT_SEQ_INVERSE_EN
      inv_q       <= 1'b0;
      tw_conj_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      bfly_q      <= bfly_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
      wr_addr_a_q <= wr_addr_a_d;
      wr_addr_b_q <= wr_addr_b_d;
`ifdef FFT_SEQ_INVERSE_EN
      inv_q       <= inv_d;
      tw_conj_q   <= tw_conj_d;
`endif
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_stage     = stage_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr_a = rd_addr_a_q;
  assign o_rd_addr_b = rd_addr_b_q;
  assign o_tw_addr   = tw_addr_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr_a = wr_addr_a_q;
  assign o_wr_addr_b = wr_addr_b_q;
`ifdef FFT_SEQ_INVERSE_EN
  assign o_tw_conj   = tw_conj_q;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: address trace vs. a closed-form model, timing, and an
// end-to-end FFT through a RAM/butterfly model compared with a direct DFT.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;
  localparam int  LOG2N   = 3;
  localparam int  N       = 1 << LOG2N;
  localparam int  NB      = N / 2;
  localparam int  NBF     = LOG2N * NB;
  localparam int  RUN_CYC = LOG2N * N;
  localparam real PI      = 3.14159265358979323846;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
  logic i_inverse = 1'b0;
  logic o_tw_conj;
`endif
  logic             o_busy, o_done, o_rd_en, o_wr_en;
  logic [LOG2N-1:0] o_stage, o_rd_addr_a, o_rd_addr_b, o_wr_addr_a, o_wr_addr_b;
  logic [LOG2N-2:0] o_tw_addr;

  fft_stage_sequencer #(.LOG2N(LOG2N), .RD_LAT(1)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
`ifdef FFT_SEQ_INVERSE_EN
    .i_inverse  (i_inverse),
    .o_tw_conj  (o_tw_conj),
`endif
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_stage    (o_stage),
    .o_rd_en    (o_rd_en),
    .o_rd_addr_a(o_rd_addr_a),
    .o_rd_addr_b(o_rd_addr_b),
    .o_tw_addr  (o_tw_addr),
    .o_wr_en    (o_wr_en),
    .o_wr_addr_a(o_wr_addr_a),
    .o_wr_addr_b(o_wr_addr_b)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Reference trace built directly from the butterfly index arithmetic.
  int exp_a[NBF], exp_b[NBF], exp_tw[NBF], exp_s[NBF];

  // Monitor-owned state (written only by the monitor process).
  int  rd_a_q[$], rd_b_q[$], rd_tw_q[$], rd_s_q[$], rd_c_q[$];
  int  wr_a_q[$], wr_b_q[$], done_c_q[$];
  int  busy_cnt = 0, alt_err = 0, conj_wr = 0, conj_other = 0, load_ack = 0;
  bit  last_rd = 1'b0;
  real ram_re[N], ram_im[N];
  real cap_a_re, cap_a_im, cap_b_re, cap_b_im, w_re, w_im, t_re, t_im;
  int  cap_k;

  // Test-owned RAM preload, copied in by the monitor on request.
  real init_re[N], init_im[N];
  int  load_req = 0;

  always @(negedge i_clk) begin
    if (load_req != load_ack) begin
      for (int i = 0; i < N; i++) begin
        ram_re[i] = init_re[i];
        ram_im[i] = init_im[i];
      end
      load_ack = load_req;
    end
    if (o_busy) begin
      busy_cnt++;
      if (o_rd_en == o_wr_en || (o_rd_en && last_rd) || (o_wr_en && !last_rd)) alt_err++;
      last_rd = o_rd_en;
    end else begin
      if (o_rd_en || o_wr_en) alt_err++;
      last_rd = 1'b0;
    end
    if (o_rd_en) begin
      rd_a_q.push_back(int'(o_rd_addr_a));
      rd_b_q.push_back(int'(o_rd_addr_b));
      rd_tw_q.push_back(int'(o_tw_addr));
      rd_s_q.push_back(int'(o_stage));
      rd_c_q.push_back(cyc);
      cap_a_re = ram_re[o_rd_addr_a];
      cap_a_im = ram_im[o_rd_addr_a];
      cap_b_re = ram_re[o_rd_addr_b];
      cap_b_im = ram_im[o_rd_addr_b];
      cap_k    = int'(o_tw_addr);
    end
    if (o_wr_en) begin
      wr_a_q.push_back(int'(o_wr_addr_a));
      wr_b_q.push_back(int'(o_wr_addr_b));
      w_re = $cos(2.0 * PI * real'(cap_k) / real'(N));
      w_im = -$sin(2.0 * PI * real'(cap_k) / real'(N));
      t_re = w_re * cap_b_re - w_im * cap_b_im;
      t_im = w_re * cap_b_im + w_im * cap_b_re;
      ram_re[o_wr_addr_a] = cap_a_re + t_re;
      ram_im[o_wr_addr_a] = cap_a_im + t_im;
      ram_re[o_wr_addr_b] = cap_a_re - t_re;
      ram_im[o_wr_addr_b] = cap_a_im - t_im;
    end
    if (o_done) done_c_q.push_back(cyc);
`ifdef FFT_SEQ_INVERSE_EN
    if (o_tw_conj) begin
      if (o_wr_en) conj_wr++;
      else conj_other++;
    end
`endif
  end

  function automatic logic [6*LOG2N+2:0] all_outs();
    return {o_busy, o_done, o_rd_en, o_wr_en, o_stage, o_rd_addr_a, o_rd_addr_b,
            o_tw_addr, o_wr_addr_a, o_wr_addr_b};
  endfunction

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic real fabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic build_model();
    int h, pos, grp, idx;
    for (int s = 0; s < LOG2N; s++) begin
      for (int b = 0; b < NB; b++) begin
        h   = 1 << s;
        pos = b % h;
        grp = b / h;
        idx = s * NB + b;
        exp_a[idx]  = grp * 2 * h + pos;
        exp_b[idx]  = exp_a[idx] + h;
        exp_tw[idx] = pos * (NB / h);
        exp_s[idx]  = s;
      end
    end
  endtask

  // Pulse i_start, wait (bounded) for o_done. t = cycle count right after the start edge.
  task automatic do_run(input int gap, output int t, output bit timeout);
    repeat (gap) @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk);
    #1 t = cyc;
    i_start = 1'b0;
`ifdef FFT_SEQ_INVERSE_EN
    i_inverse = ~i_inverse;  // latched with i_start, so this must not affect the run
`endif
    timeout = 1'b1;
    for (int i = 0; i < RUN_CYC + 20; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        timeout = 1'b0;
        break;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    int bb;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_hold: outputs=%h required 0", all_outs());
    end
    i_rst_n = 1'b1;
    bb = busy_cnt;
    repeat (5) @(negedge i_clk);
    n_vec++;
    if (all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_release: outputs=%h required 0", all_outs());
    end
    n_vec++;
    if (busy_cnt - bb !== 0) begin
      n_err++;
      $display("FAIL reset_idle: busy cycles=%0d required 0", busy_cnt - bb);
    end
    $display("reset: outputs=%h busy=%0b", all_outs(), o_busy);
  endtask

  task automatic test_full_run();
    int t, rb, wb, bb, db, ab;
    bit to;
    for (int run = 0; run < 3; run++) begin
      rb = rd_a_q.size(); wb = wr_a_q.size(); bb = busy_cnt; db = done_c_q.size(); ab = alt_err;
      do_run($urandom_range(0, 6), t, to);
      n_vec++;
      if (to !== 1'b0) begin
        n_err++;
        $display("FAIL full_run%0d timeout: o_done not seen within %0d cycles", run, RUN_CYC + 20);
      end
      n_vec++;
      if (rd_a_q.size() - rb !== NBF || wr_a_q.size() - wb !== NBF) begin
        n_err++;
        $display("FAIL full_run%0d counts: rd=%0d wr=%0d required %0d", run,
                 rd_a_q.size() - rb, wr_a_q.size() - wb, NBF);
      end
      n_vec++;
      if (busy_cnt - bb !== RUN_CYC || alt_err - ab !== 0) begin
        n_err++;
        $display("FAIL full_run%0d busy: busy=%0d alt_err=%0d required %0d/0", run,
                 busy_cnt - bb, alt_err - ab, RUN_CYC);
      end
      n_vec++;
      if (rd_c_q[rb] !== t || done_c_q.size() - db !== 1 || done_c_q[db] !== t + RUN_CYC) begin
        n_err++;
        $display("FAIL full_run%0d timing: first_rd=%0d done=%0d x%0d required %0d/%0d x1", run,
                 rd_c_q[rb] - t, done_c_q[db] - t, done_c_q.size() - db, 0, RUN_CYC);
      end
      for (int i = 0; i < NBF; i++) begin
        n_vec++;
        if (rd_a_q[rb+i] !== exp_a[i] || rd_b_q[rb+i] !== exp_b[i] ||
            rd_tw_q[rb+i] !== exp_tw[i] || rd_s_q[rb+i] !== exp_s[i]) begin
          n_err++;
          $display("FAIL full_run%0d rd[%0d]: got s%0d (%0d,%0d,%0d) required s%0d (%0d,%0d,%0d)",
                   run, i, rd_s_q[rb+i], rd_a_q[rb+i], rd_b_q[rb+i], rd_tw_q[rb+i],
                   exp_s[i], exp_a[i], exp_b[i], exp_tw[i]);
        end
        n_vec++;
        if (wr_a_q[wb+i] !== exp_a[i] || wr_b_q[wb+i] !== exp_b[i]) begin
          n_err++;
          $display("FAIL full_run%0d wr[%0d]: got (%0d,%0d) required (%0d,%0d)",
                   run, i, wr_a_q[wb+i], wr_b_q[wb+i], exp_a[i], exp_b[i]);
        end
      end
      $display("full_run%0d: start=%0d done=+%0d busy=%0d", run, t, done_c_q[db] - t, busy_cnt - bb);
    end
  endtask

  task automatic test_end_to_end();
    real xr[N], xi[N];
    real er, ei, ang, d;
    int  t;
    bit  to;
    for (int set = 0; set < 3; set++) begin
      for (int n = 0; n < N; n++) begin
        if (set == 0) begin
          xr[n] = (n == 0) ? 262144.0 : 0.0;
          xi[n] = 0.0;
        end else begin
          xr[n] = real'($urandom_range(0, 2000)) - 1000.0;
          xi[n] = real'($urandom_range(0, 2000)) - 1000.0;
        end
      end
      for (int n = 0; n < N; n++) begin
        init_re[bitrev(n)] = xr[n];
        init_im[bitrev(n)] = xi[n];
      end
      load_req++;
      repeat (2) @(negedge i_clk);
      do_run($urandom_range(0, 4), t, to);
      n_vec++;
      if (to !== 1'b0) begin
        n_err++;
        $display("FAIL e2e%0d timeout: o_done not seen", set);
      end
      for (int k = 0; k < N; k++) begin
        er = 0.0;
        ei = 0.0;
        for (int n = 0; n < N; n++) begin
          ang = -2.0 * PI * real'(n * k) / real'(N);
          er += xr[n] * $cos(ang) - xi[n] * $sin(ang);
          ei += xr[n] * $sin(ang) + xi[n] * $cos(ang);
        end
        d = fabs(ram_re[k] - er) + fabs(ram_im[k] - ei);
        n_vec++;
        if (d > 1.0e-3) begin
          n_err++;
          $display("FAIL e2e%0d bin%0d: got (%f,%f) required (%f,%f)", set, k,
                   ram_re[k], ram_im[k], er, ei);
        end
      end
      $display("e2e%0d: bin0=(%f,%f) bin1=(%f,%f)", set, ram_re[0], ram_im[0], ram_re[1], ram_im[1]);
    end
  endtask

  task automatic test_ignored_start();
    int  t, rb, bb, db, at;
    bit  seen;
    for (int run = 0; run < 2; run++) begin
      at = (run == 0) ? 10 : int'($urandom_range(1, RUN_CYC - 1));
      rb = rd_a_q.size(); bb = busy_cnt; db = done_c_q.size();
      repeat (3) @(posedge i_clk);
      #1 i_start = 1'b1;
      @(posedge i_clk);
      #1 t = cyc;
      i_start = 1'b0;
      repeat (at - 1) @(posedge i_clk);
      #1 i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < RUN_CYC + 20; i++) begin
        @(negedge i_clk);
        if (o_done) begin
          seen = 1'b1;
          break;
        end
      end
      if (seen) begin
        i_start = 1'b1;  // high during DONE: must also be ignored
        @(posedge i_clk);
        #1 i_start = 1'b0;
      end
      repeat (RUN_CYC + 10) @(negedge i_clk);
      n_vec++;
      if (seen !== 1'b1 || done_c_q.size() - db !== 1) begin
        n_err++;
        $display("FAIL ignored_start%0d done: pulses=%0d required 1", run, done_c_q.size() - db);
      end
      n_vec++;
      if (done_c_q[db] !== t + RUN_CYC) begin
        n_err++;
        $display("FAIL ignored_start%0d done_time: +%0d required +%0d", run, done_c_q[db] - t, RUN_CYC);
      end
      n_vec++;
      if (rd_a_q.size() - rb !== NBF || busy_cnt - bb !== RUN_CYC || o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL ignored_start%0d run: rd=%0d busy=%0d required %0d/%0d", run,
                 rd_a_q.size() - rb, busy_cnt - bb, NBF, RUN_CYC);
      end
      $display("ignored_start%0d: extra start at cycle %0d, done pulses=%0d", run, at, done_c_q.size() - db);
    end
  endtask

  task automatic test_reset_midop();
    int k, t, wb, rb, db, bb, wcnt;
    bit hit, to;
    k  = $urandom_range(0, NB - 1);
    wb = wr_a_q.size(); db = done_c_q.size();
    repeat (2) @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wcnt = 0;
    hit  = 1'b0;
    for (int i = 0; i < RUN_CYC + 4; i++) begin
      @(negedge i_clk);
      if (o_wr_en) wcnt++;
      if (wcnt == NB + k + 1) begin
        hit = 1'b1;
        break;
      end
    end
    n_vec++;
    if (hit !== 1'b1 || o_stage !== LOG2N'(1) || o_wr_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_midop locate: hit=%0b stage=%0d wr_en=%0b required 1/1/1", hit, o_stage, o_wr_en);
    end
    #1 i_rst_n = 1'b0;
    #1;
    n_vec++;
    if (o_wr_en !== 1'b0 || all_outs() !== '0) begin
      n_err++;
      $display("FAIL reset_midop async: wr_en=%0b outputs=%h required 0", o_wr_en, all_outs());
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    bb = busy_cnt;
    repeat (12) @(negedge i_clk);
    n_vec++;
    if (wr_a_q.size() - wb !== NB + k + 1 || done_c_q.size() - db !== 0 || busy_cnt - bb !== 0) begin
      n_err++;
      $display("FAIL reset_midop abort: writes=%0d done=%0d busy=%0d required %0d/0/0",
               wr_a_q.size() - wb, done_c_q.size() - db, busy_cnt - bb, NB + k + 1);
    end
    rb = rd_a_q.size(); wb = wr_a_q.size(); bb = busy_cnt; db = done_c_q.size();
    do_run($urandom_range(0, 3), t, to);
    n_vec++;
    if (to !== 1'b0 || busy_cnt - bb !== RUN_CYC || done_c_q.size() - db !== 1 ||
        done_c_q[db] !== t + RUN_CYC) begin
      n_err++;
      $display("FAIL reset_midop rerun: timeout=%0b busy=%0d done=%0d required 0/%0d/1", to,
               busy_cnt - bb, done_c_q.size() - db, RUN_CYC);
    end
    for (int i = 0; i < NBF; i++) begin
      n_vec++;
      if (rd_a_q[rb+i] !== exp_a[i] || rd_b_q[rb+i] !== exp_b[i] || wr_a_q[wb+i] !== exp_a[i]) begin
        n_err++;
        $display("FAIL reset_midop trace[%0d]: got rd(%0d,%0d) wr %0d required (%0d,%0d)", i,
                 rd_a_q[rb+i], rd_b_q[rb+i], wr_a_q[wb+i], exp_a[i], exp_b[i]);
      end
    end
    $display("reset_midop: reset at stage1 butterfly %0d, rerun busy=%0d", k, busy_cnt - bb);
  endtask

`ifdef FFT_SEQ_INVERSE_EN
  task automatic test_inverse();
    int t, rb, cw, co;
    bit to;
    for (int run = 0; run < 2; run++) begin
      i_inverse = (run == 0);
      rb = rd_a_q.size(); cw = conj_wr; co = conj_other;
      do_run(2, t, to);
      n_vec++;
      if (to !== 1'b0) begin
        n_err++;
        $display("FAIL inverse%0d timeout: o_done not seen", run);
      end
      n_vec++;
      if (conj_wr - cw !== ((run == 0) ? NBF : 0) || conj_other - co !== 0) begin
        n_err++;
        $display("FAIL inverse%0d tw_conj: wr=%0d other=%0d required %0d/0", run,
                 conj_wr - cw, conj_other - co, (run == 0) ? NBF : 0);
      end
      for (int i = 0; i < NBF; i++) begin
        n_vec++;
        if (rd_a_q[rb+i] !== exp_a[i] || rd_b_q[rb+i] !== exp_b[i] || rd_tw_q[rb+i] !== exp_tw[i]) begin
          n_err++;
          $display("FAIL inverse%0d rd[%0d]: got (%0d,%0d,%0d) required (%0d,%0d,%0d)", run, i,
                   rd_a_q[rb+i], rd_b_q[rb+i], rd_tw_q[rb+i], exp_a[i], exp_b[i], exp_tw[i]);
        end
      end
      $display("inverse%0d: conj in WR=%0d", run, conj_wr - cw);
    end
  endtask
`endif

  initial begin
    build_model();
    test_reset();
    test_full_run();
    test_end_to_end();
    test_ignored_start();
    test_reset_midop();
`ifdef FFT_SEQ_INVERSE_EN
    test_inverse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control FSM that runs an in-place radix-2 DIT FFT over a dual-port sample RAM using the combinational butterfly_sum datapath.
- Generates RAM read/write addresses, twiddle-ROM addresses and enables for every butterfly of every stage, then pulses done.
- Sample order in RAM is bit-reversed before start; the block performs no data arithmetic.
- Data path: RAM read ports -> butterfly_sum i_A/i_B, twiddle ROM -> i_twiddle, o_A/o_B -> RAM write ports.

Parameters:
- LOG2N, 3, log2 of FFT length N (N = 2^LOG2N); legal range 2..12.
- RD_LAT, 1, RAM read latency in cycles; fixed at 1 in this revision, and any other value is a $error at elaboration.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  start request; sampled only in IDLE.
- o_busy  out  1  high from the first RD cycle through the last WR cycle.
- o_done  out  1  one-cycle pulse after the final write.
- o_stage  out  LOG2N  current stage index s.
- o_rd_en  out  1  read strobe to both RAM ports.
- o_rd_addr_a  out  LOG2N  port A read address.
- o_rd_addr_b  out  LOG2N  port B read address.
- o_tw_addr  out  LOG2N-1  twiddle ROM address (N/2 entries, W_N^k).
- o_wr_en  out  1  write strobe to both RAM ports.
- o_wr_addr_a  out  LOG2N  port A write address.
- o_wr_addr_b  out  LOG2N  port B write address.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; stage and butterfly counters 0. Reset asserted mid-run aborts immediately and writes nothing further; the run restarts only on a new i_start.
- States:
  - IDLE: i_start=1 -> RD; counters cleared.
  - RD: o_rd_en=1 with addresses for (s,b) -> WR.
  - WR: o_wr_en=1; write addresses equal the previous RD addresses, held in registers; RAM data and twiddle valid this cycle. Not last -> RD; last (s=LOG2N-1, b=N/2-1) -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Addressing for stage s and butterfly b (0..N/2-1), with h=2^s:
  - pos = b & (h-1); grp = b >> s.
  - addr_a = (grp << (s+1)) | pos; addr_b = addr_a + h.
  - tw = pos << (LOG2N-1-s).
- Counter wrap: b increments in WR; at b=N/2-1 b wraps to 0 and s increments. The last stage never wraps s, so the run terminates.
- Hazards: no RD/WR overlap, so read-after-write is always safe; the next RD is issued the cycle after the previous WR.
- Timing: i_start high at edge t -> first RD cycle t+1. Total busy cycles = LOG2N*N; o_done in cycle t+1+LOG2N*N.
- i_start while busy or in DONE: ignored, not queued.
- o_stage is valid in RD/WR and holds its last value otherwise; addresses are don't-care when their strobe is low but must be driven as registers, never X after reset.
- All outputs are registered; there is no combinational path from i_start.

Optional Feature:
- Macro FFT_SEQ_INVERSE_EN.
- Defined:
  - Adds port i_inverse (in, 1), sampled with i_start and held for the whole run.
  - Adds port o_tw_conj (out, 1) = latched i_inverse during WR, 0 otherwise; external logic negates the twiddle imag when it is high.
  - The block's addresses are unchanged.
- Undefined: neither port exists and the behaviour is forward FFT only.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles, release -> all outputs 0, state IDLE, o_busy=0.
- Full run, LOG2N=3, pulse i_start -> (a,b,tw) sequence:
  - s0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - s1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - s2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - Expected: RD/WR alternate, o_busy high 24 cycles, o_done pulse at t+25.
- End to end: run with a RAM model holding the bit-reversed impulse x[0]=1.0 (1<<18 real) -> all 8 bins equal 1<<18 real, 0 imag.
- Ignored start: assert i_start during cycle 10 of a run -> no restart; o_done exactly once; no second run.
- Reset mid-op: drop i_rst_n in a WR cycle of stage 1 -> o_wr_en goes 0 asynchronously; after release the block is IDLE, and the next i_start gives a full 24-cycle run.
- FFT_SEQ_INVERSE_EN defined, i_inverse=1 -> same address trace as the full-run scenario, o_tw_conj=1 in every WR cycle; with i_inverse=0 -> o_tw_conj stays 0.
